// File: rtl/onehot_dec_seq_if.sv
// Control and status bundle for onehot_dec_seq: enable, mode and select in; one-hot, index and
// wrap out.
interface onehot_dec_seq_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic             sel_vld;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  // Controller side: drives enable/mode/select, observes the decoder state.
  modport master (
    output en, mode, sel, sel_vld,
    input  out, idx, wrap
  );

  // Decoder side.
  modport slave (
    input  en, mode, sel, sel_vld,
    output out, idx, wrap
  );
endinterface

// File: rtl/onehot_dec_seq.sv
// Registered binary-to-one-hot decoder with an index sequencer: direct load, upward scan,
// bounce scan or hold. All outputs come straight from flops.
module onehot_dec_seq #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DIV_MAX = 25_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  onehot_dec_seq_if.slave  bus
);
  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam int unsigned CNT_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV_MAX - 1);
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] OneHot0 = OUT_W'(1);

  typedef enum logic [1:0] {
    ModeDirect = 2'b00,
    ModeScanUp = 2'b01,
    ModeBounce = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_q;
  mode_e            mode_in;
  logic             tick;

  assign mode_in = mode_e'(bus.mode);
  assign tick    = (cnt_q == CntLast);

  // Next-state: disable beats mode change, which beats scan tick / direct load.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    out_d  = '0;
    if (bus.en) begin
      if (mode_in != mode_q) begin
        // Mode switch edge: restart the divider, keep the index where it is.
        cnt_d = '0;
        if (mode_in == ModeBounce) begin
          dir_d = (idx_q == IdxLast) ? DirDown : DirUp;
        end
      end else begin
        unique case (mode_in)
          ModeDirect: begin
            cnt_d = '0;
            if (bus.sel_vld) begin
              idx_d = bus.sel;
            end
          end
          ModeScanUp: begin
            if (tick) begin
              cnt_d  = '0;
              idx_d  = idx_q + 1'b1;
              wrap_d = (idx_q == IdxLast);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ModeBounce: begin
            if (tick) begin
              cnt_d = '0;
              if (dir_q == DirUp) begin
                idx_d = idx_q + 1'b1;
                if (idx_d == IdxLast) begin
                  dir_d = DirDown;
                end
              end else begin
                idx_d = idx_q - 1'b1;
                if (idx_d == '0) begin
                  dir_d  = DirUp;
                  wrap_d = 1'b1;
                end
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ModeHold: begin
            // Everything frozen; out is re-derived from the frozen index.
          end
        endcase
      end
      out_d = OneHot0 << idx_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q  <= '0;
      out_q  <= OneHot0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
      dir_q  <= DirUp;
      mode_q <= mode_in;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_in;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Bench for onehot_dec_seq: three instances (SEL_W 3/2/1) share one stimulus stream and are
// checked every cycle against an integer model, plus directed literal expectations.
module tb_onehot_dec_seq;
  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       sel_vld;
  logic       started;

  int n_cmp;
  int n_bad;

  localparam int SW[3] = '{3, 2, 1};
  localparam int DM[3] = '{4, 1, 1};

  typedef struct packed {
    int idx;
    int dir;
    int cnt;
    int mq;
    int out;
    int wrap;
  } mstate_t;

  mstate_t m[3];

  onehot_dec_seq_if #(.SEL_W(3)) if_a ();
  onehot_dec_seq_if #(.SEL_W(2)) if_b ();
  onehot_dec_seq_if #(.SEL_W(1)) if_c ();

  assign if_a.en = en;  assign if_a.mode = mode;  assign if_a.sel = sel;
  assign if_b.en = en;  assign if_b.mode = mode;  assign if_b.sel = sel[1:0];
  assign if_c.en = en;  assign if_c.mode = mode;  assign if_c.sel = sel[0:0];
  assign if_a.sel_vld = sel_vld;
  assign if_b.sel_vld = sel_vld;
  assign if_c.sel_vld = sel_vld;

  onehot_dec_seq #(.SEL_W(3), .DIV_MAX(4)) u_a (.sys_clk(clk), .sys_rst(rst), .bus(if_a));
  onehot_dec_seq #(.SEL_W(2), .DIV_MAX(1)) u_b (.sys_clk(clk), .sys_rst(rst), .bus(if_b));
  onehot_dec_seq #(.SEL_W(1), .DIV_MAX(1)) u_c (.sys_clk(clk), .sys_rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: integer position, direction +1/-1, step counter.
  function automatic mstate_t mstep(input mstate_t s, input int sel_w, input int div_max,
                                    input bit r, input bit e, input int md, input int sl,
                                    input bit sv);
    mstate_t n = s;
    int npos = 1 << sel_w;
    n.wrap = 0;
    if (r) begin
      n.idx = 0; n.dir = 1; n.cnt = 0; n.mq = md; n.out = 1;
      return n;
    end
    n.mq = md;
    if (!e) begin
      n.out = 0;
      return n;
    end
    if (md != s.mq) begin
      n.cnt = 0;
      if (md == 2) n.dir = (s.idx == npos - 1) ? -1 : 1;
    end else begin
      case (md)
        0: begin
          n.cnt = 0;
          if (sv) n.idx = sl % npos;
        end
        1, 2: begin
          if (s.cnt == div_max - 1) begin
            n.cnt = 0;
            if (md == 1) begin
              n.idx  = (s.idx + 1) % npos;
              n.wrap = (n.idx == 0) ? 1 : 0;
            end else begin
              n.idx = s.idx + s.dir;
              if (n.idx == npos - 1) n.dir = -1;
              else if (n.idx == 0) begin
                n.dir  = 1;
                n.wrap = 1;
              end
            end
          end else begin
            n.cnt = s.cnt + 1;
          end
        end
        default: ;
      endcase
    end
    n.out = 1 << n.idx;
    return n;
  endfunction

  // Advance the model on every rising edge with the inputs the DUTs see.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m[i] <= mstep(m[i], SW[i], DM[i], rst, en, int'(mode), int'(sel), sel_vld);
    end
    if (rst) started <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a.out",  32'(if_a.out),  32'(m[0].out));
    chk("a.idx",  32'(if_a.idx),  32'(m[0].idx));
    chk("a.wrap", 32'(if_a.wrap), 32'(m[0].wrap));
    chk("b.out",  32'(if_b.out),  32'(m[1].out));
    chk("b.idx",  32'(if_b.idx),  32'(m[1].idx));
    chk("b.wrap", 32'(if_b.wrap), 32'(m[1].wrap));
    chk("c.out",  32'(if_c.out),  32'(m[2].out));
    chk("c.idx",  32'(if_c.idx),  32'(m[2].idx));
    chk("c.wrap", 32'(if_c.wrap), 32'(m[2].wrap));
  endtask

  // n rising edges; model compare on each falling edge, return 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (started) compare_all();
      @(posedge clk);
      #1;
    end
  endtask

  int seq_b[7] = '{1, 2, 3, 2, 1, 0, 1};

  initial begin
    started = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = '0; sel_vld = 1'b0;
    @(posedge clk); #1;
    step(2);
    chk("reset out", 32'(if_a.out), 32'd1);
    chk("reset idx", 32'(if_a.idx), 32'd0);
    chk("reset wrap", 32'(if_a.wrap), 32'd0);
    rst = 1'b0;

    // Direct load and sweep.
    en = 1'b1; sel = 3'd5; sel_vld = 1'b1;
    step(1);
    chk("direct out", 32'(if_a.out), 32'h20);
    chk("direct idx", 32'(if_a.idx), 32'd5);
    sel_vld = 1'b0; sel = 3'd2;
    step(1);
    chk("direct hold", 32'(if_a.idx), 32'd5);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s); sel_vld = 1'b1;
      step(1);
      chk("sweep out", 32'(if_a.out), 32'(1 << s));
      chk("sweep onehot", 32'($countones(if_a.out)), 32'd1);
    end

    // Scan up from 6 with DIV_MAX=4.
    sel = 3'd6; sel_vld = 1'b1;
    step(1);
    sel_vld = 1'b0; mode = 2'b01;
    step(1);
    step(4);
    chk("scan idx7", 32'(if_a.idx), 32'd7);
    chk("scan nowrap", 32'(if_a.wrap), 32'd0);
    step(3);
    chk("scan still7", 32'(if_a.idx), 32'd7);
    step(1);
    chk("scan idx0", 32'(if_a.idx), 32'd0);
    chk("scan wrap", 32'(if_a.wrap), 32'd1);
    chk("scan out0", 32'(if_a.out), 32'd1);
    step(1);
    chk("wrap single", 32'(if_a.wrap), 32'd0);

    // Disable with div_cnt=2, then resume.
    step(1);
    en = 1'b0;
    step(10);
    chk("dis out", 32'(if_a.out), 32'd0);
    chk("dis idx", 32'(if_a.idx), 32'd0);
    en = 1'b1;
    step(1);
    chk("resume out", 32'(if_a.out), 32'd1);
    chk("resume idx", 32'(if_a.idx), 32'd0);
    step(1);
    chk("resume step", 32'(if_a.idx), 32'd1);

    // Hold freezes, then bounce entered at the top end.
    step(2);
    mode = 2'b11;
    step(1);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("hold out", 32'(if_a.out), 32'd2);
    end
    mode = 2'b00; sel = 3'd7; sel_vld = 1'b1;
    step(1);
    chk("modechg ignores load", 32'(if_a.idx), 32'd1);
    step(1);
    sel_vld = 1'b0; mode = 2'b11;
    step(1);
    mode = 2'b10;
    step(1);
    chk("bounce entry", 32'(if_a.idx), 32'd7);
    step(3);
    chk("bounce wait", 32'(if_a.idx), 32'd7);
    step(1);
    chk("bounce first", 32'(if_a.idx), 32'd6);
    step(8);
    chk("bounce at4", 32'(if_a.idx), 32'd4);

    // Reset mid-bounce, then all three restart upward.
    rst = 1'b1;
    step(1);
    chk("rst idx", 32'(if_a.idx), 32'd0);
    chk("rst out", 32'(if_a.out), 32'd1);
    chk("rst wrap", 32'(if_a.wrap), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk("b bounce idx", 32'(if_b.idx), 32'(seq_b[k]));
      chk("b bounce wrap", 32'(if_b.wrap), (k == 5) ? 32'd1 : 32'd0);
      chk("c bounce idx", 32'(if_c.idx), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("c bounce wrap", 32'(if_c.wrap), (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    chk("a restart up", 32'(if_a.idx), 32'd1);

    // Single-bit scan up.
    mode = 2'b01;
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
